pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage openmips core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Merges stall requests from ID (operand hazard) and EX (multi-cycle ops, e.g. div/madd).
//  Owns the EX busy counter and drives one-cycle pipeline flushes with a redirect PC.
//  Drives per-stage stall enables to pc_reg and all pipeline registers.
// PARAMETERS
//  CNT_W  6   width of EX busy counter; max multi-cycle length 2^CNT_W-1
//  PC_W   32  width of redirect PC (matches InstAddrBus)
// PORTS
//  clk             in   1      system clock, all state on rising edge
//  rst             in   1      synchronous, active-high reset
//  stallreq_id_i   in   1      ID hazard stall request, level, combinational
//  ex_start_i      in   1      EX starts a multi-cycle op this cycle
//  ex_cycles_i     in   CNT_W  total stall cycles for that op, sampled with ex_start_i
//  flush_req_i     in   1      redirect/exception request, single-cycle pulse
//  flush_pc_i      in   PC_W   redirect target, sampled with flush_req_i
//  stall_o         out  6      [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB; 1 = hold
//  flush_o         out  1      clear all pipeline registers this cycle
//  new_pc_o        out  PC_W   PC load value, valid while flush_o=1
//  ex_busy_o       out  1      EX multi-cycle op in progress
//  ex_done_o       out  1      pulse in last stall cycle of an EX op
//  stall_cycles_o  out  32     perf counter, see CONFIGURATION
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, cnt=0, flush_o=0, new_pc_o=0, ex_busy_o=0,
//   ex_done_o=0, stall_cycles_o=0. While rst=1, stall_o=0 combinationally.
//  States: IDLE, EX_BUSY, FLUSH. Priority in every cycle: flush_req_i > EX > ID.
//  stall_o is combinational from state/inputs (same-cycle effect); flush_o,new_pc_o registered.
//  IDLE:
//   flush_req_i=1 -> latch flush_pc_i, next state FLUSH; stall_o=0 this cycle; ex_start_i ignored.
//   else ex_start_i=1, ex_cycles_i=N>0 -> stall_o=6'b001111 this cycle; cnt<=N-1;
//    N=1: ex_done_o=1 this cycle, stay IDLE; N>1: next state EX_BUSY.
//   else ex_start_i=1, N=0 -> no stall, stays IDLE (single-cycle op).
//   else stallreq_id_i=1 -> stall_o=6'b000111; else stall_o=0.
//  EX_BUSY: ex_busy_o=1; stall_o=6'b001111 (stallreq_id_i/ex_start_i ignored); cnt decrements;
//   cnt==1 -> ex_done_o=1 this cycle, next IDLE. Total stalled cycles for op = N exactly.
//   flush_req_i=1 -> abort: cnt<=0, no ex_done_o, stall_o=0, latch PC, next FLUSH.
//  FLUSH: exactly one cycle; flush_o=1, new_pc_o=latched PC, stall_o=0; next IDLE.
//   flush_req_i again in FLUSH -> relatch PC, stay FLUSH one more cycle (back-to-back flush).
//  ex_done_o, ex_busy_o are combinational from state/cnt; flush_o/new_pc_o registered outputs.
//  new_pc_o holds last latched value when flush_o=0; consumers qualify with flush_o.
//  Reset mid-op: any state -> IDLE at next edge, pending EX op and flush discarded.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: stall_cycles_o counts cycles with stall_o!=0,
//   saturates at 32'hFFFF_FFFF, cleared by rst.
//  Not defined: counter logic absent, stall_cycles_o tied to 32'h0.
// TESTING
//  T1 reset: rst=1 two cycles with all requests high -> stall_o=0, flush_o=0, new_pc_o=0.
//  T2 ID stall: stallreq_id_i=1 three cycles -> stall_o=6'b000111 those exact cycles, then 0.
//  T3 EX op: ex_start_i=1, ex_cycles_i=4 -> stall_o=6'b001111 for 4 cycles, ex_done_o on 4th,
//     IDLE on 5th; stallreq_id_i=1 during EX_BUSY does not change stall_o.
//  T4 abort: ex_cycles_i=10, flush_req_i=1 with flush_pc_i=32'h0000_0100 at 3rd stall cycle ->
//     next cycle flush_o=1, new_pc_o=32'h100, stall_o=0, ex_done_o never asserted.
//  T5 collision: ex_start_i=1 and flush_req_i=1 same cycle (pc 32'h0000_0200) -> stall_o=0,
//     one FLUSH cycle with new_pc_o=32'h200, then IDLE, ex_busy_o stays 0.
//  T6 perf (PIPE_CTRL_PERF_EN): T2 then T3 -> stall_cycles_o=7; without macro stays 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//  Interface that carries the request/response signals between the openmips
//  pipeline stages and the pipeline sequencing controller.
//  Signals:
//   stallreq_id_i   ID hazard stall request (level)
//   ex_start_i      EX begins a multi-cycle op this cycle
//   ex_cycles_i     total stall cycles of that op, sampled with ex_start_i
//   flush_req_i     redirect/exception request (single-cycle pulse)
//   flush_pc_i      redirect target, sampled with flush_req_i
//   stall_o         per-stage hold: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   flush_o         clear all pipeline registers this cycle
//   new_pc_o        PC load value, valid while flush_o=1
//   ex_busy_o       EX multi-cycle op in progress
//   ex_done_o       pulse in the last stall cycle of an EX op
//   stall_cycles_o  stalled-cycle performance counter
//  Modports: master = pipeline side (drives requests), slave = controller.
interface pipe_ctrl_if #(
   parameter int CNT_W = 6,
   parameter int PC_W  = 32
);
   logic             stallreq_id_i;
   logic             ex_start_i;
   logic [CNT_W-1:0] ex_cycles_i;
   logic             flush_req_i;
   logic [PC_W-1:0]  flush_pc_i;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [PC_W-1:0]  new_pc_o;
   logic             ex_busy_o;
   logic             ex_done_o;
   logic [31:0]      stall_cycles_o;

   modport master (
      output stallreq_id_i, ex_start_i, ex_cycles_i, flush_req_i, flush_pc_i,
      input  stall_o, flush_o, new_pc_o, ex_busy_o, ex_done_o, stall_cycles_o
   );

   modport slave (
      input  stallreq_id_i, ex_start_i, ex_cycles_i, flush_req_i, flush_pc_i,
      output stall_o, flush_o, new_pc_o, ex_busy_o, ex_done_o, stall_cycles_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//  Pipeline sequencing controller for the 5-stage openmips core. Merges the ID
//  hazard stall and EX multi-cycle stall requests, owns the EX busy counter and
//  issues one-cycle pipeline flushes with a redirect PC.
//  Ports:
//   clk  system clock, all state on rising edge
//   rst  synchronous active-high reset
//   bus  pipe_ctrl_if.slave (requests in, stall/flush/status out)
//  Optional feature: define PIPE_CTRL_PERF_EN to enable the saturating
//  stalled-cycle counter on stall_cycles_o; otherwise it is tied to zero.
module pipe_ctrl #(
   parameter int CNT_W = 6,
   parameter int PC_W  = 32
) (
   input  logic      clk,
   input  logic      rst,
   pipe_ctrl_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] EX_BUSY = 2'd1;
   localparam logic [1:0] FLUSH   = 2'd2;

   localparam logic [5:0] STALL_ID = 6'b000111;
   localparam logic [5:0] STALL_EX = 6'b001111;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] exCnt_q, exCnt_d;
   logic             flush_q, flush_d;
   logic [PC_W-1:0]  newPc_q, newPc_d;
   logic [5:0]       stallVec;
   logic             exDone;

   // Next-state and same-cycle outputs. A flush request always wins: it
   // suppresses any stall, aborts a running EX op without a done pulse and
   // captures the redirect PC. The EX counter is loaded with N-1 in the start
   // cycle, so the start cycle plus the EX_BUSY cycles add up to exactly N.
   // While reset is asserted the stall and done outputs are forced low so the
   // pipeline is never held by garbage state.
   always_comb begin
      state_d  = state_q;
      exCnt_d  = exCnt_q;
      flush_d  = 1'b0;
      newPc_d  = newPc_q;
      stallVec = 6'b000000;
      exDone   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.flush_req_i) begin
               newPc_d = bus.flush_pc_i;
               flush_d = 1'b1;
               state_d = FLUSH;
            end else if (bus.ex_start_i && (bus.ex_cycles_i != '0)) begin
               stallVec = STALL_EX;
               exCnt_d  = bus.ex_cycles_i - CNT_W'(1);
               if (bus.ex_cycles_i == CNT_W'(1)) begin
                  exDone = 1'b1;
               end else begin
                  state_d = EX_BUSY;
               end
            end else if (bus.ex_start_i) begin
               stallVec = 6'b000000;
            end else if (bus.stallreq_id_i) begin
               stallVec = STALL_ID;
            end
         end
         EX_BUSY: begin
            if (bus.flush_req_i) begin
               exCnt_d = '0;
               newPc_d = bus.flush_pc_i;
               flush_d = 1'b1;
               state_d = FLUSH;
            end else begin
               stallVec = STALL_EX;
               exCnt_d  = exCnt_q - CNT_W'(1);
               if (exCnt_q == CNT_W'(1)) begin
                  exDone  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         FLUSH: begin
            if (bus.flush_req_i) begin
               newPc_d = bus.flush_pc_i;
               flush_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rst) begin
         stallVec = 6'b000000;
         exDone   = 1'b0;
      end
   end

   // State registers. Reset discards any pending EX op or flush; the latched
   // PC is cleared too so new_pc_o starts from a known value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         exCnt_q <= '0;
         flush_q <= 1'b0;
         newPc_q <= '0;
      end else begin
         state_q <= state_d;
         exCnt_q <= exCnt_d;
         flush_q <= flush_d;
         newPc_q <= newPc_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stallCycles_q;

   // Count every cycle in which any stage is held, sticking at all-ones
   // rather than wrapping so a long run never reports a small number.
   always_ff @(posedge clk) begin
      if (rst) begin
         stallCycles_q <= '0;
      end else if ((stallVec != 6'b000000) && (stallCycles_q != 32'hFFFF_FFFF)) begin
         stallCycles_q <= stallCycles_q + 32'd1;
      end
   end

   assign bus.stall_cycles_o = stallCycles_q;
`else
   assign bus.stall_cycles_o = 32'h0;
`endif

   // Output mapping: stall and done are same-cycle, flush and PC registered.
   assign bus.stall_o   = stallVec;
   assign bus.ex_done_o = exDone;
   assign bus.ex_busy_o = (state_q == EX_BUSY);
   assign bus.flush_o   = flush_q;
   assign bus.new_pc_o  = newPc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//  Directed testbench for pipe_ctrl. Inputs change on the falling edge and
//  outputs are sampled 1 time unit later, well away from the rising edge.
module tb_pipe_ctrl;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pipe_ctrl_if #(.CNT_W(6), .PC_W(32)) bus ();

   pipe_ctrl #(.CNT_W(6), .PC_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle worth of inputs at the falling edge, then settle.
   task automatic applyStimulus(input logic r, input logic id, input logic start,
                                input logic [5:0] cycles, input logic freq,
                                input logic [31:0] fpc);
      @(negedge clk);
      rst               = r;
      bus.stallreq_id_i = id;
      bus.ex_start_i    = start;
      bus.ex_cycles_i   = cycles;
      bus.flush_req_i   = freq;
      bus.flush_pc_i    = fpc;
      #1;
   endtask

   // Check the five status outputs in one go.
   task automatic checkAll(input string tag, input logic [5:0] stall,
                           input logic flush, input logic [31:0] pc,
                           input logic busy, input logic done);
      checkOutput({tag, ".stall"}, {26'd0, bus.stall_o}, {26'd0, stall});
      checkOutput({tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, flush});
      checkOutput({tag, ".newpc"}, bus.new_pc_o, pc);
      checkOutput({tag, ".busy"},  {31'd0, bus.ex_busy_o}, {31'd0, busy});
      checkOutput({tag, ".done"},  {31'd0, bus.ex_done_o}, {31'd0, done});
   endtask

   logic [31:0] perfExp;

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst               = 1'b1;
      bus.stallreq_id_i = 1'b0;
      bus.ex_start_i    = 1'b0;
      bus.ex_cycles_i   = 6'd0;
      bus.flush_req_i   = 1'b0;
      bus.flush_pc_i    = 32'h0;

      // T1: reset with every request high
      applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
      checkOutput("t1.stall0", {26'd0, bus.stall_o}, 32'd0);
      applyStimulus(1, 1, 1, 6'd5, 1, 32'hDEAD_BEEF);
      checkOutput("t1.stall1", {26'd0, bus.stall_o}, 32'd0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t1.post", 6'b000000, 0, 32'h0, 0, 0);
      checkOutput("t1.perf", bus.stall_cycles_o, 32'd0);

      // T2: ID stall for three cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 6'd0, 0, 32'h0);
         checkOutput("t2.stall", {26'd0, bus.stall_o}, 32'h07);
      end
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkOutput("t2.release", {26'd0, bus.stall_o}, 32'h00);

      // T3: four-cycle EX op, ID request ignored while busy
      applyStimulus(0, 0, 1, 6'd4, 0, 32'h0);
      checkAll("t3.c1", 6'b001111, 0, 32'h0, 0, 0);
      applyStimulus(0, 1, 0, 6'd0, 0, 32'h0);
      checkAll("t3.c2", 6'b001111, 0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 6'd0, 0, 32'h0);
      checkAll("t3.c3", 6'b001111, 0, 32'h0, 1, 0);
      applyStimulus(0, 1, 0, 6'd0, 0, 32'h0);
      checkAll("t3.c4", 6'b001111, 0, 32'h0, 1, 1);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t3.c5", 6'b000000, 0, 32'h0, 0, 0);

      // T6: perf counter after T2 + T3
`ifdef PIPE_CTRL_PERF_EN
      perfExp = 32'd7;
`else
      perfExp = 32'd0;
`endif
      checkOutput("t6.perf", bus.stall_cycles_o, perfExp);

      // T4: abort a ten-cycle op at its third stall cycle
      applyStimulus(0, 0, 1, 6'd10, 0, 32'h0);
      checkAll("t4.c1", 6'b001111, 0, 32'h0, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t4.c2", 6'b001111, 0, 32'h0, 1, 0);
      applyStimulus(0, 0, 0, 6'd0, 1, 32'h0000_0100);
      checkAll("t4.c3", 6'b000000, 0, 32'h0, 1, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t4.c4", 6'b000000, 1, 32'h100, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t4.c5", 6'b000000, 0, 32'h100, 0, 0);

      // T5: EX start collides with flush request
      applyStimulus(0, 0, 1, 6'd3, 1, 32'h0000_0200);
      checkAll("t5.c1", 6'b000000, 0, 32'h100, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t5.c2", 6'b000000, 1, 32'h200, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("t5.c3", 6'b000000, 0, 32'h200, 0, 0);

      // Single-cycle-length EX op: done in the start cycle, no busy
      applyStimulus(0, 0, 1, 6'd1, 0, 32'h0);
      checkAll("n1.c1", 6'b001111, 0, 32'h200, 0, 1);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("n1.c2", 6'b000000, 0, 32'h200, 0, 0);

      // Zero-length EX op beats a simultaneous ID request
      applyStimulus(0, 1, 1, 6'd0, 0, 32'h0);
      checkAll("n0.c1", 6'b000000, 0, 32'h200, 0, 0);

      // Back-to-back flush relatches the PC
      applyStimulus(0, 0, 0, 6'd0, 1, 32'h0000_0300);
      checkOutput("bb.c1.flush", {31'd0, bus.flush_o}, 32'd0);
      applyStimulus(0, 0, 0, 6'd0, 1, 32'h0000_0304);
      checkAll("bb.c2", 6'b000000, 1, 32'h300, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("bb.c3", 6'b000000, 1, 32'h304, 0, 0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("bb.c4", 6'b000000, 0, 32'h304, 0, 0);

      // Reset in the middle of an EX op
      applyStimulus(0, 0, 1, 6'd10, 0, 32'h0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkOutput("rm.busy", {31'd0, bus.ex_busy_o}, 32'd1);
      applyStimulus(1, 1, 0, 6'd0, 0, 32'h0);
      checkOutput("rm.stall", {26'd0, bus.stall_o}, 32'd0);
      applyStimulus(0, 0, 0, 6'd0, 0, 32'h0);
      checkAll("rm.post", 6'b000000, 0, 32'h0, 0, 0);
      checkOutput("rm.perf", bus.stall_cycles_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
